// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline WB has absolute priority, MDU results
// wait in a one-entry hold register and drain into free WB slots.
module rf_write_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        hold_valid,
  output logic [4:0]  hold_addr,
  output logic [31:0] hold_data,
  output logic        starve_stall
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STARVE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] MAX_M1_C   = CNT_W'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic              hold_valid_q, hold_valid_d;
  logic [4:0]        hold_addr_q, hold_addr_d;
  logic [31:0]       hold_data_q, hold_data_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              starve_stall_q, starve_stall_d;

  logic wb_real_s;
  logic slot_free_s;
  logic drain_s;
  logic kill_s;
  logic release_s;
  logic accept_s;
  logic load_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign wb_real_s   = wb_we & (wb_addr != 5'd0);
  assign slot_free_s = ~wb_real_s;
  assign drain_s     = hold_valid_q & slot_free_s;
  // A younger pipeline write to the same register makes the held result stale.
  assign kill_s      = hold_valid_q & wb_real_s & (wb_addr == hold_addr_q);
  assign release_s   = drain_s | kill_s;
  assign mdu_ready   = ~reset & (~hold_valid_q | release_s);
  assign accept_s    = mdu_valid & mdu_ready;
  assign load_s      = accept_s & (mdu_addr != 5'd0);
  assign cnt_inc_s   = (wait_cnt_q < MAX_WAIT_C) ? (wait_cnt_q + CNT_W'(1)) : wait_cnt_q;

  // Next-state logic for the hold register, wait counter and starvation request.
  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (load_s) begin
          state_d     = ST_WAIT;
          hold_addr_d = mdu_addr;
          hold_data_d = mdu_data;
          wait_cnt_d  = {CNT_W{1'b0}};
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_WAIT, ST_STARVE: begin
        if (release_s) begin
          wait_cnt_d = {CNT_W{1'b0}};
          if (load_s) begin
            state_d     = ST_WAIT;
            hold_addr_d = mdu_addr;
            hold_data_d = mdu_data;
          end else begin
            state_d     = ST_EMPTY;
            hold_addr_d = 5'd0;
            hold_data_d = 32'd0;
          end
        end else begin
          wait_cnt_d = cnt_inc_s;
          if ((state_q == ST_STARVE) || (wait_cnt_q >= MAX_M1_C)) begin
            state_d = ST_STARVE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      default: begin
        state_d     = ST_EMPTY;
        hold_addr_d = 5'd0;
        hold_data_d = 32'd0;
        wait_cnt_d  = {CNT_W{1'b0}};
      end
    endcase
    hold_valid_d   = (state_d != ST_EMPTY);
    starve_stall_d = (state_d == ST_STARVE);
  end

  // State registers; reset discards any held entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_EMPTY;
      hold_valid_q   <= 1'b0;
      hold_addr_q    <= 5'd0;
      hold_data_q    <= 32'd0;
      wait_cnt_q     <= {CNT_W{1'b0}};
      starve_stall_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_valid_q   <= hold_valid_d;
      hold_addr_q    <= hold_addr_d;
      hold_data_q    <= hold_data_d;
      wait_cnt_q     <= wait_cnt_d;
      starve_stall_q <= starve_stall_d;
    end
  end

  // Write-port mux: real WB write first, otherwise drain the hold register.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 5'd0;
    rf_data = 32'd0;
    if (reset) begin
      rf_we   = 1'b0;
      rf_addr = 5'd0;
      rf_data = 32'd0;
    end else if (wb_real_s) begin
      rf_we   = 1'b1;
      rf_addr = wb_addr;
      rf_data = wb_data;
    end else if (hold_valid_q) begin
      rf_we   = 1'b1;
      rf_addr = hold_addr_q;
      rf_data = hold_data_q;
    end else begin
      rf_we   = 1'b0;
      rf_addr = 5'd0;
      rf_data = 32'd0;
    end
  end

  assign hold_valid   = hold_valid_q;
  assign hold_addr    = hold_addr_q;
  assign hold_data    = hold_data_q;
  assign starve_stall = starve_stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations (MAX_WAIT=4).
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        hold_valid;
  logic [4:0]  hold_addr;
  logic [31:0] hold_data;
  logic        starve_stall;

  int n_checks = 0;
  int n_pass   = 0;

  rf_write_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .mdu_valid    (mdu_valid),
    .mdu_addr     (mdu_addr),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .hold_valid   (hold_valid),
    .hold_addr    (hold_addr),
    .hold_data    (hold_data),
    .starve_stall (starve_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we     = we;
    wb_addr   = wa;
    wb_data   = wd;
    mdu_valid = mv;
    mdu_addr  = ma;
    mdu_data  = md;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd5, 32'h0000_0055);
    #2;
    chk("rst_hold_valid", {31'd0, hold_valid}, 32'd0);
    chk("rst_hold_addr", {27'd0, hold_addr}, 32'd0);
    chk("rst_hold_data", hold_data, 32'd0);
    chk("rst_starve", {31'd0, starve_stall}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_mdu_ready", {31'd0, mdu_ready}, 32'd0);
    tick();
    reset = 1'b0;

    // 1: idle pipeline, single MDU result drains one cycle after accept
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234_5678);
    chk("t1_ready", {31'd0, mdu_ready}, 32'd1);
    chk("t1_no_bypass", {31'd0, rf_we}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t1_hold_valid", {31'd0, hold_valid}, 32'd1);
    chk("t1_rf_we", {31'd0, rf_we}, 32'd1);
    chk("t1_rf_addr", {27'd0, rf_addr}, 32'd5);
    chk("t1_rf_data", rf_data, 32'h1234_5678);
    tick();
    chk("t1_hold_clear", {31'd0, hold_valid}, 32'd0);
    chk("t1_rf_idle", {31'd0, rf_we}, 32'd0);

    // 2: continuous WB writes starve the held entry
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd7, 32'h7777_7777);
    chk("t2_ready", {31'd0, mdu_ready}, 32'd1);
    chk("t2_wb_pass", {27'd0, rf_addr}, 32'd3);
    tick();
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0);
    chk("t2_hold_valid", {31'd0, hold_valid}, 32'd1);
    chk("t2_ready_busy", {31'd0, mdu_ready}, 32'd0);
    chk("t2_wb_data", rf_data, 32'h0000_0033);
    for (int k = 0; k < 4; k++) begin
      chk("t2_no_starve_yet", {31'd0, starve_stall}, 32'd0);
      tick();
    end
    chk("t2_starve", {31'd0, starve_stall}, 32'd1);
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd8, 32'h8888_8888);
    chk("t2_ready_starve", {31'd0, mdu_ready}, 32'd0);
    tick();
    chk("t2_starve_hold", {31'd0, starve_stall}, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t2_drain_we", {31'd0, rf_we}, 32'd1);
    chk("t2_drain_addr", {27'd0, rf_addr}, 32'd7);
    chk("t2_drain_data", rf_data, 32'h7777_7777);
    chk("t2_drain_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    chk("t2_starve_clr", {31'd0, starve_stall}, 32'd0);
    chk("t2_hold_clr", {31'd0, hold_valid}, 32'd0);
    chk("t2_rf_idle", {31'd0, rf_we}, 32'd0);

    // 3: WAW kill, younger WB write to the held register wins
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_9999);
    tick();
    drive(1'b1, 5'd9, 32'hAAAA_0000, 1'b0, 5'd0, 32'd0);
    chk("t3_rf_addr", {27'd0, rf_addr}, 32'd9);
    chk("t3_rf_data", rf_data, 32'hAAAA_0000);
    chk("t3_ready_kill", {31'd0, mdu_ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t3_hold_clr", {31'd0, hold_valid}, 32'd0);
    chk("t3_no_stale", {31'd0, rf_we}, 32'd0);

    // 4: WB write to $0 counts as a free slot
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h4444_4444);
    tick();
    drive(1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 5'd0, 32'd0);
    chk("t4_we", {31'd0, rf_we}, 32'd1);
    chk("t4_addr", {27'd0, rf_addr}, 32'd4);
    chk("t4_data", rf_data, 32'h4444_4444);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t4_hold_clr", {31'd0, hold_valid}, 32'd0);

    // 5: back-to-back MDU stream
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h0000_0011);
    chk("t5_ready0", {31'd0, mdu_ready}, 32'd1);
    chk("t5_idle0", {31'd0, rf_we}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h0000_0022);
    chk("t5_ready1", {31'd0, mdu_ready}, 32'd1);
    chk("t5_addr1", {27'd0, rf_addr}, 32'd1);
    chk("t5_data1", rf_data, 32'h0000_0011);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_0033);
    chk("t5_ready2", {31'd0, mdu_ready}, 32'd1);
    chk("t5_addr2", {27'd0, rf_addr}, 32'd2);
    chk("t5_data2", rf_data, 32'h0000_0022);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t5_we3", {31'd0, rf_we}, 32'd1);
    chk("t5_addr3", {27'd0, rf_addr}, 32'd3);
    chk("t5_data3", rf_data, 32'h0000_0033);
    tick();
    chk("t5_hold_clr", {31'd0, hold_valid}, 32'd0);

    // MDU result to $0 is accepted and dropped
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_00FF);
    chk("z_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("z_hold", {31'd0, hold_valid}, 32'd0);
    chk("z_rf_we", {31'd0, rf_we}, 32'd0);

    // 6: asynchronous reset while starving
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd6, 32'h6666_6666);
    tick();
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    chk("t6_starve", {31'd0, starve_stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_hold_rst", {31'd0, hold_valid}, 32'd0);
    chk("t6_starve_rst", {31'd0, starve_stall}, 32'd0);
    chk("t6_we_rst", {31'd0, rf_we}, 32'd0);
    chk("t6_ready_rst", {31'd0, mdu_ready}, 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t6_no_write0", {31'd0, rf_we}, 32'd0);
    tick();
    chk("t6_no_write1", {31'd0, rf_we}, 32'd0);
    chk("t6_hold_after", {31'd0, hold_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite / Write_register / Write_data) between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- The pipeline WB always has priority and never stalls. MDU results enter a one-entry hold register and drain into free WB slots.
- A starvation counter requests a pipeline bubble when an MDU result has waited too long.
- Sits between the WB stage / MDU and the register file. Hold contents are exported so the hazard/forwarding logic can see them.

Parameters:
- MAX_WAIT, 4, cycles an entry may wait in the hold register before starve_stall is raised (legal range 1..15).
- CNT_W, 4, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wb_we  in  1  pipeline WB write enable.
- wb_addr  in  5  pipeline WB destination register.
- wb_data  in  32  pipeline WB data.
- mdu_valid  in  1  MDU result valid.
- mdu_addr  in  5  MDU destination register.
- mdu_data  in  32  MDU result data.
- mdu_ready  out  1  hold register can accept an MDU result this cycle.
- rf_we  out  1  drives register-file RegWrite.
- rf_addr  out  5  drives register-file Write_register.
- rf_data  out  32  drives register-file Write_data.
- hold_valid  out  1  hold register occupied (for hazard/forwarding).
- hold_addr  out  5  destination register of the held entry.
- hold_data  out  32  data of the held entry.
- starve_stall  out  1  registered request to the hazard unit to insert a WB bubble.

Behaviour:
- Reset: hold_valid=0, hold_addr=0, hold_data=0, wait_cnt=0, starve_stall=0, state=EMPTY. While reset is high: rf_we=0, mdu_ready=0.
- slot_free = ~wb_we | (wb_addr==0). A WB write to $0 counts as an empty slot.
- Port mux (combinational):
  - If wb_we & wb_addr!=0: rf_* = wb_*.
  - Else if hold_valid: rf_we=1, rf_addr=hold_addr, rf_data=hold_data. This is the drain.
  - Else: rf_we=0, rf_addr=0, rf_data=0.
- drain = hold_valid & slot_free.
- kill = hold_valid & wb_we & (wb_addr==hold_addr) & wb_addr!=0. The pipeline write is younger (WAW), so the held entry is discarded without being written.
- mdu_ready = ~reset & (~hold_valid | drain | kill). Supports one accept per cycle, back-to-back.
- Accept = mdu_valid & mdu_ready. The entry is loaded at the next edge, so the minimum latency from MDU to register-file write is 1 cycle. There is no same-cycle bypass.
- MDU entries with mdu_addr==0 are accepted (mdu_ready honoured) and discarded; hold_valid is not set.
- State machine:
  - EMPTY: hold_valid=0. On accept of an addr!=0 entry -> WAIT.
  - WAIT: hold_valid=1. wait_cnt increments each cycle without drain/kill. When wait_cnt reaches MAX_WAIT-1 with no drain -> STARVE.
  - STARVE: hold_valid=1, starve_stall=1 (registered, asserted the cycle after entry). Exit on drain or kill.
  - From WAIT or STARVE, on drain or kill: if a new entry is accepted the same cycle -> WAIT with wait_cnt=0; otherwise -> EMPTY with wait_cnt=0. starve_stall clears on the following cycle.
- wait_cnt saturates at MAX_WAIT and never wraps.
- Reset mid-operation discards any held entry; no register-file write is issued for it.
- The pipeline WB is never blocked or modified by this block.

Test Plan:
1. Idle pipeline (wb_we=0), MDU presents addr=5, data=0x12345678 -> mdu_ready=1. Next cycle: rf_we=1, rf_addr=5, rf_data=0x12345678, hold_valid=1. Following cycle: hold_valid=0.
2. Continuous wb_we=1 to addr 3, MDU entry addr=7, MAX_WAIT=4 -> starve_stall rises 4 cycles after hold_valid. Then drop wb_we for 1 cycle -> rf_addr=7 written, starve_stall=0 on the next cycle.
3. Hold contains addr=9 while WB writes addr=9 data=0xAAAA0000 -> rf gets 0xAAAA0000, hold_valid=0 next cycle, and 0x… from the MDU is never written.
4. WB writes addr=0 with wb_we=1 while hold contains addr=4 -> drain occurs: rf_addr=4, rf_we=1.
5. MDU streams 3 results (addr 1,2,3) on consecutive cycles with wb_we=0 -> mdu_ready stays 1. Register-file writes occur to 1, 2, 3 on consecutive cycles, each 1 cycle after its accept.
6. Assert reset asynchronously while in STARVE -> hold_valid, starve_stall and rf_we go to 0 immediately. After release, no write to the held address occurs.
